// File: rtl/imem_refill_responder.sv
// Instruction-memory refill responder: returns a 16-byte line as four critical-word-first beats.
// First beat LATENCY cycles after accept; a stalled beat holds until rsp_ready, requests are taken only when idle.
module imem_refill_responder #(
   parameter int LATENCY    = 4,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_idx,
   output logic        rsp_last,
   input  logic        prog_we,
   input  logic [31:0] prog_addr,
   input  logic [31:0] prog_data
);

   typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

   state_t      state_q, state_d;
   logic        req_ready_q, req_ready_d;
   logic [27:0] line_q, line_d;
   logic [1:0]  start_q, start_d;
   logic [1:0]  beat_q, beat_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic [1:0]  rsp_idx_q, rsp_idx_d;
   logic        rsp_last_q, rsp_last_d;

   logic        load_beat;
   logic [1:0]  load_idx;
   logic [29:0] rd_word_addr;
   logic [31:0] rd_word;
   logic        unused_bits;

   logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

   // Backing store has no reset so program contents survive rst_n.
   always_ff @(posedge clk) begin
      if (prog_we) begin
         mem[prog_addr[DEPTH_LOG2+1:2]] <= prog_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      line_d      = line_q;
      start_d     = start_q;
      beat_d      = beat_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_idx_d   = rsp_idx_q;
      rsp_last_d  = rsp_last_q;
      load_beat   = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               line_d      = req_addr[31:4];
               start_d     = req_addr[3:2];
               cnt_d       = 4'(LATENCY - 1);
               req_ready_d = 1'b0;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               beat_d    = 2'd0;
               load_beat = 1'b1;
               state_d   = BURST;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         BURST: begin
            if (rsp_ready) begin
               if (beat_q == 2'd3) begin
                  rsp_valid_d = 1'b0;
                  rsp_last_d  = 1'b0;
                  req_ready_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  beat_d    = beat_q + 2'd1;
                  load_beat = 1'b1;
               end
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            req_ready_d = 1'b1;
            state_d     = IDLE;
         end
      endcase

      // The read uses pre-edge memory contents, so a same-edge write does not reach this beat.
      load_idx     = start_q + beat_d;
      rd_word_addr = {line_q, load_idx};
      rd_word      = mem[rd_word_addr[DEPTH_LOG2-1:0]];
      if (load_beat) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = rd_word;
         rsp_idx_d   = load_idx;
         rsp_last_d  = (beat_d == 2'd3);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b1;
         line_q      <= '0;
         start_q     <= '0;
         beat_q      <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_idx_q   <= '0;
         rsp_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         line_q      <= line_d;
         start_q     <= start_d;
         beat_q      <= beat_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_idx_q   <= rsp_idx_d;
         rsp_last_q  <= rsp_last_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_idx   = rsp_idx_q;
   assign rsp_last  = rsp_last_q;

   assign unused_bits = ^{req_addr[1:0], prog_addr[1:0], prog_addr[31:DEPTH_LOG2+2],
                          rd_word_addr[29:DEPTH_LOG2]};

endmodule

// File: tb/tb_imem_refill_responder.sv
// Directed bench for imem_refill_responder: table of refills plus hand-written stall, busy, collision and reset cases.
module tb_imem_refill_responder;
   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_idx;
   logic        rsp_last;
   logic        prog_we = 1'b0;
   logic [31:0] prog_addr = '0;
   logic [31:0] prog_data = '0;

   int checks = 0;
   int failures = 0;
   int xfer_cnt = 0;

   imem_refill_responder #(.LATENCY(LAT), .DEPTH_LOG2(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_idx(rsp_idx), .rsp_last(rsp_last),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) xfer_cnt++;
   end

   typedef struct packed {
      logic [31:0]       addr;
      logic [3:0][1:0]   idx;
      logic [3:0][31:0]  data;
   } vec_t;

   vec_t vecs [5];

   function automatic vec_t mk(input logic [31:0] a,
                               input logic [1:0] i0, input logic [1:0] i1,
                               input logic [1:0] i2, input logic [1:0] i3,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3);
      vec_t v;
      v.addr = a;
      v.idx[0] = i0; v.idx[1] = i1; v.idx[2] = i2; v.idx[3] = i3;
      v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
      return v;
   endfunction

   task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s_%s actual=%h required=%h at %0t", tag, what, act, exp, $time);
      end
   endtask

   task automatic expect_beat(input string tag, input logic [1:0] idx, input logic [31:0] data, input logic last);
      check(tag, "valid", {31'd0, rsp_valid}, 32'd1);
      check(tag, "idx", {30'd0, rsp_idx}, {30'd0, idx});
      check(tag, "data", rsp_data, data);
      check(tag, "last", {31'd0, rsp_last}, {31'd0, last});
   endtask

   task automatic write_word(input logic [31:0] a, input logic [31:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   // Called at a negedge with the block idle; returns at the negedge where req_ready is back.
   task automatic run_refill(input vec_t v, input string tag);
      int base;
      check(tag, "req_ready_pre", {31'd0, req_ready}, 32'd1);
      base = xfer_cnt;
      req_valid = 1'b1; req_addr = v.addr;
      @(negedge clk);
      req_valid = 1'b0;
      check(tag, "req_ready_busy", {31'd0, req_ready}, 32'd0);
      for (int k = 0; k < LAT; k++) begin
         check(tag, "valid_in_wait", {31'd0, rsp_valid}, 32'd0);
         @(negedge clk);
      end
      for (int b = 0; b < 4; b++) begin
         expect_beat(tag, v.idx[b], v.data[b], b == 3);
         @(negedge clk);
      end
      check(tag, "req_ready_post", {31'd0, req_ready}, 32'd1);
      check(tag, "valid_post", {31'd0, rsp_valid}, 32'd0);
      check(tag, "xfers", xfer_cnt - base, 32'd4);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int stray;

      vecs[0] = mk(32'h0000_0000, 2'd0, 2'd1, 2'd2, 2'd3, 32'h11, 32'h22, 32'h33, 32'h44);
      vecs[1] = mk(32'h0000_000A, 2'd2, 2'd3, 2'd0, 2'd1, 32'h33, 32'h44, 32'h11, 32'h22);
      vecs[2] = mk(32'h0000_0017, 2'd1, 2'd2, 2'd3, 2'd0, 32'h66, 32'h77, 32'h88, 32'h55);
      vecs[3] = mk(32'h0000_100C, 2'd3, 2'd0, 2'd1, 2'd2, 32'h44, 32'h11, 32'h22, 32'h33);
      vecs[4] = mk(32'h0000_0FFC, 2'd3, 2'd0, 2'd1, 2'd2, 32'hA3, 32'hA0, 32'hA1, 32'hA2);

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset", "req_ready", {31'd0, req_ready}, 32'd1);
      check("reset", "rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset", "rsp_data", rsp_data, 32'd0);
      check("reset", "rsp_idx", {30'd0, rsp_idx}, 32'd0);
      check("reset", "rsp_last", {31'd0, rsp_last}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) write_word(32'(i * 4), 32'(32'h11 * (i + 1)));
      for (int i = 0; i < 4; i++) write_word(32'h0FF0 + 32'(i * 4), 32'hA0 + 32'(i));

      // Table: back-to-back refills at minimum spacing
      for (int i = 0; i < 5; i++) run_refill(vecs[i], $sformatf("vec%0d", i));

      // Backpressure on beat 1 for three cycles, with a write to its word during the stall
      base = xfer_cnt;
      req_valid = 1'b1; req_addr = 32'h0;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (LAT) @(negedge clk);
      expect_beat("bp_b0", 2'd0, 32'h11, 1'b0);
      @(negedge clk);
      expect_beat("bp_b1", 2'd1, 32'h22, 1'b0);
      rsp_ready = 1'b0;
      prog_we = 1'b1; prog_addr = 32'h4; prog_data = 32'hDEAD_0001;
      @(negedge clk);
      prog_we = 1'b0;
      for (int k = 0; k < 2; k++) begin
         expect_beat("bp_hold", 2'd1, 32'h22, 1'b0);
         @(negedge clk);
      end
      expect_beat("bp_hold", 2'd1, 32'h22, 1'b0);
      rsp_ready = 1'b1;
      @(negedge clk);
      expect_beat("bp_b2", 2'd2, 32'h33, 1'b0);
      @(negedge clk);
      expect_beat("bp_b3", 2'd3, 32'h44, 1'b1);
      @(negedge clk);
      check("bp", "req_ready_post", {31'd0, req_ready}, 32'd1);
      check("bp", "xfers", xfer_cnt - base, 32'd4);
      write_word(32'h4, 32'h22);

      // Request while busy is dropped
      base = xfer_cnt;
      req_valid = 1'b1; req_addr = 32'h0;
      @(negedge clk);
      req_addr = 32'h10;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      for (int b = 0; b < 4; b++) begin
         expect_beat("busy", 2'(b), 32'(32'h11 * (b + 1)), b == 3);
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("busy", "valid_after", {31'd0, rsp_valid}, 32'd0);
      check("busy", "xfers", xfer_cnt - base, 32'd4);

      // Wrapped address with writes racing the burst
      req_valid = 1'b1; req_addr = 32'h1000;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (LAT) @(negedge clk);
      expect_beat("col_b0", 2'd0, 32'h11, 1'b0);
      prog_we = 1'b1; prog_addr = 32'hC; prog_data = 32'hCAFE_0003;
      @(negedge clk);
      expect_beat("col_b1", 2'd1, 32'h22, 1'b0);
      prog_addr = 32'h8; prog_data = 32'hCAFE_0002;
      @(negedge clk);
      prog_we = 1'b0;
      expect_beat("col_b2_old", 2'd2, 32'h33, 1'b0);
      @(negedge clk);
      expect_beat("col_b3_new", 2'd3, 32'hCAFE_0003, 1'b1);
      @(negedge clk);
      check("col", "req_ready_post", {31'd0, req_ready}, 32'd1);
      write_word(32'h8, 32'h33);
      write_word(32'hC, 32'h44);

      // Reset in the middle of a burst
      req_valid = 1'b1; req_addr = 32'h10;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (LAT) @(negedge clk);
      expect_beat("rst_b0", 2'd0, 32'h55, 1'b0);
      @(negedge clk);
      expect_beat("rst_b1", 2'd1, 32'h66, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_mid", "rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_mid", "req_ready", {31'd0, req_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base = xfer_cnt;
      stray = 0;
      repeat (12) begin
         @(negedge clk);
         if (rsp_valid) stray++;
      end
      check("rst_after", "valid_cycles", 32'(stray), 32'd0);
      check("rst_after", "xfers", xfer_cnt - base, 32'd0);
      run_refill(vecs[2], "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/imem_refill_responder.md
IMEM_REFILL_RESPONDER -- requirements
Module: imem_refill_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter LATENCY, default 4: cycles from request accept to the first response beat; legal range 1..15.
REQ-003 Parameter DEPTH_LOG2, default 10: the backing store SHALL hold 2^DEPTH_LOG2 32-bit words.
REQ-004 Port clk  in  1  rising-edge clock.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Port req_valid  in  1  the cache requests a line refill.
REQ-007 Port req_ready  out  1  the responder can accept a request.
REQ-008 Port req_addr  in  32  byte address of the missed word.
REQ-009 Port rsp_valid  out  1  rsp_data holds a valid beat.
REQ-010 Port rsp_ready  in  1  the cache accepts the current beat.
REQ-011 Port rsp_data  out  32  instruction word.
REQ-012 Port rsp_idx  out  2  word index of the beat within the 16-byte line.
REQ-013 Port rsp_last  out  1  the current beat is the fourth beat of the line.
REQ-014 Port prog_we  in  1  backing-store write enable.
REQ-015 Port prog_addr  in  32  byte address for the write.
REQ-016 Port prog_data  in  32  write data.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and BURST.
REQ-018 req_ready SHALL be 1 only in IDLE.
REQ-019 A request is accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-020 On accept, the block SHALL latch line = req_addr[31:4] and start = req_addr[3:2], then enter WAIT.
REQ-021 req_addr[1:0] SHALL be ignored.
REQ-022 In WAIT, a down-counter loaded with LATENCY-1 SHALL run; the first beat SHALL be valid exactly LATENCY cycles after the accept edge (LATENCY=1 means the next cycle).
REQ-023 In BURST, the block SHALL emit four beats in critical-word-first order: rsp_idx = (start + beat) mod 4, with beat = 0..3.
REQ-024 rsp_data for each beat SHALL equal mem[{line, rsp_idx} mod 2^DEPTH_LOG2], i.e. high address bits are discarded.
REQ-025 A beat transfers on an edge where rsp_valid=1 and rsp_ready=1; the next beat, if any, SHALL be valid in the following cycle.
REQ-026 While rsp_valid=1 and rsp_ready=0, rsp_data, rsp_idx and rsp_last SHALL hold stable.
REQ-027 rsp_last SHALL be 1 only for beat 3.
REQ-028 When the last beat transfers, the FSM SHALL return to IDLE, so req_ready=1 in the next cycle.
REQ-029 The minimum request-to-request spacing SHALL be LATENCY+4+1 cycles with rsp_ready held high.
REQ-030 rsp_valid SHALL be 0 in IDLE and WAIT.
REQ-031 All response outputs SHALL be registered.
REQ-032 req_valid asserted while the block is not in IDLE SHALL be ignored, with no queuing.
REQ-033 prog_we=1 SHALL write prog_data to mem[prog_addr[DEPTH_LOG2+1:2]] at the rising edge, in any state.
REQ-034 A write to the word being loaded into rsp_data on the same edge SHALL NOT affect that beat (read-before-write); a word written before its beat is loaded SHALL appear in that beat.
REQ-035 A beat already presented and stalled SHALL NOT change if its word is written.

Reset
REQ-036 With rst_n=0: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_idx=0, rsp_last=0, counters=0.
REQ-037 Reset asserted mid-WAIT or mid-BURST SHALL abort the refill immediately; no further beats SHALL be produced after rst_n returns high.
REQ-038 Reset SHALL NOT clear the backing store.

Verification
REQ-039 Aligned refill: mem[0..3]=0x11,0x22,0x33,0x44, LATENCY=4, req_addr=0x0 accepted at edge T, rsp_ready=1 -> beats at T+4..T+7 with idx 0,1,2,3, data 0x11..0x44, rsp_last only at T+7, req_ready=1 at T+8.
REQ-040 Critical word first: req_addr=0xA -> idx order 2,3,0,1, with data mem[2],mem[3],mem[0],mem[1].
REQ-041 Backpressure: rsp_ready=0 for 3 cycles on beat 1 -> beat 1 held stable with idx=1, no beat lost or duplicated, four transfers total.
REQ-042 Busy request: req_valid pulsed during WAIT -> ignored, and only one burst is produced.
REQ-043 Wrap and collision: DEPTH_LOG2=10, req_addr=0x1000 -> data from mem[0..3]; prog_we to mem[3] two cycles before beat 3 is loaded -> beat 3 returns the new value.
REQ-044 Reset mid-burst: rst_n=0 after beat 1 -> rsp_valid=0 at once; after release, req_ready=1 and no stray beats occur.
